lod_pipe: RTL and testbench
===========================

// Module: lod_pipe
// PURPOSE
//  Parametrised, pipelined leading-one detector with valid/ready handshake.
//  Returns the bit index of the most-significant set bit of a WIDTH-bit word, plus a zero flag.
//  Two-stage pipeline: per-group local detection, then group selection.
//  Used by datapath normalisation logic (FP align/normalise, priority arbitration) at full clock rate.
// PARAMETERS
//  WIDTH  32                  input word width; multiple of GROUP, >= GROUP
//  GROUP  8                   stage-1 group width; power of two, >= 2
//  IDX_W  $clog2(WIDTH)       width of the index output; derived, not overridden
// PORTS
//  clk      in   1       clock, rising edge
//  rst_n    in   1       asynchronous active-low reset
//  in_vld   in   1       input word valid
//  in_rdy   out  1       block can accept a word this cycle
//  in_data  in   WIDTH   word to scan
//  out_vld  out  1       result valid
//  out_rdy  in   1       downstream accepts result this cycle
//  out_idx  out  IDX_W   index of MSB set bit (bit WIDTH-1 -> WIDTH-1, bit 0 -> 0)
//  out_zero out  1       1 when in_data was all zeros
//  out_data out  WIDTH   normalised word (present only with LOD_NORM_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_vld=0, out_vld=0, out_idx=0, out_zero=0, out_data=0.
//    Any words in flight are discarded; no result is produced for them.
//  - Transfer occurs on a rising edge where vld&rdy are both high (in and out sides independently).
//  - Stage 1 (S1), registered on an input transfer:
//    * per group g: any_g = |group bits; loc_g = index of MSB one within the group.
//    * stores WIDTH/GROUP any flags, loc fields, and the word if LOD_NORM_EN is set.
//  - Stage 2 (output register), loaded from S1 when S1 advances:
//    * picks the highest g with any_g=1.
//    * out_idx = g*GROUP + loc_g; out_zero=0.
//    * if no group is set: out_idx=0, out_zero=1 (fully defined, never X).
//  - Flow control, per stage:
//    * out_adv = !out_vld | out_rdy.
//    * s1_adv  = !s1_vld | out_adv.
//    * in_rdy  = s1_adv (combinational from out_rdy; no combinational in_vld->out_vld path).
//  - Latency: 2 cycles from input transfer to out_vld with out_rdy held high.
//    Throughput 1 word/cycle, and back-to-back is sustained.
//  - Stall: while out_vld=1 and out_rdy=0, out_* hold stable and S1 holds if full.
//    in_rdy=0 only when both stages are full and stalled.
//  - Simultaneous: with the pipe full, out_rdy=1 and in_vld=1 in one cycle -> both stages
//    advance and the new word enters S1 that edge.
//  - The stage-1 loc encoder is a priority encoder (MSB wins): multiple ones resolve to the highest.
//  - Results leave in input order; nothing is dropped or duplicated.
// CONFIGURATION
//  LOD_NORM_EN defined:
//    * out_data = in_data << (WIDTH-1-out_idx), so the leading one lands at bit WIDTH-1.
//    * all-zero input -> out_data=0.
//    * the shift is computed in stage 2; latency is unchanged.
//  LOD_NORM_EN undefined:
//    * out_data port and S1 data storage are absent.
//    * index and zero flag only.
// TESTING
//  1 WIDTH=32, out_rdy=1: in 32'h8000_0000 -> 2 cycles later out_idx=31, out_zero=0;
//    in 32'h0000_0001 -> out_idx=0.
//  2 in 32'h0001_FFFF (bits 16..0 set) -> out_idx=16; in 32'h0 -> out_idx=0, out_zero=1.
//  3 Back-to-back 8 words 1<<k for k=0..7, out_rdy=1 -> out_idx 0..7 on consecutive cycles, in order.
//  4 out_rdy=0 for 5 cycles while streaming:
//    * in_rdy drops after 2 accepts; out_idx holds.
//    * on release, all results arrive in order with none lost.
//  5 rst_n pulsed low mid-stream with both stages full -> out_vld=0 immediately (async).
//    After release: in_rdy=1, no stale output.
//  6 LOD_NORM_EN, in 32'h0000_0300 -> out_idx=9, out_data=32'hC000_0000;
//    in 32'h0 -> out_data=0, out_zero=1.

Source files
------------

// File: rtl/lod_pipe_if.sv
// lod_pipe_if: handshake/data bundle for the lod_pipe leading-one detector.
//
// Signals
//   in_vld   producer -> lod   input word valid
//   in_rdy   lod -> producer   word accepted on this edge when in_vld is high
//   in_data  producer -> lod   WIDTH-bit word to scan
//   out_vld  lod -> consumer   result valid
//   out_rdy  consumer -> lod   consumer takes the result on this edge
//   out_idx  lod -> consumer   index of the most-significant set bit
//   out_zero lod -> consumer   scanned word was all zeros
//   out_data lod -> consumer   normalised word (only when LOD_NORM_EN is defined)
//
// Modports: master = producer/consumer side, slave = the lod_pipe block.
// Build option: LOD_NORM_EN adds out_data.

interface lod_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [IDX_W-1:0] out_idx;
    logic             out_zero;
`ifdef LOD_NORM_EN
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_idx, out_zero, out_data
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_idx, out_zero, out_data
    );
`else
    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_idx, out_zero
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_idx, out_zero
    );
`endif

endinterface

// File: rtl/lod_pipe.sv
// lod_pipe: two-stage pipelined leading-one detector with valid/ready flow control.
//
// Stage 1 splits the word into WIDTH/GROUP groups and registers, per group, an "any bit set"
// flag and the local index of the group's highest one. Stage 2 (the output register) picks the
// highest non-empty group and forms the global index. Throughput is one word per cycle; a word
// presented with in_vld/in_rdy appears on out_* two cycles later when out_rdy is held high.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears both stages (in-flight words are dropped)
//   bus    lod_pipe_if.slave: in_vld/in_rdy/in_data, out_vld/out_rdy/out_idx/out_zero
//          (+ out_data when LOD_NORM_EN is defined)
//
// Parameters
//   WIDTH  word width, a multiple of GROUP (must match the interface WIDTH)
//   GROUP  stage-1 group width, power of two, >= 2
//
// Build option: define LOD_NORM_EN to also register the word in stage 1 and produce
// out_data = in_data << (WIDTH-1-out_idx) (leading one moved to bit WIDTH-1; zero stays zero).

module lod_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 8
) (
    input logic       clk,
    input logic       rst_n,
    lod_pipe_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned NGRP  = WIDTH / GROUP;
    localparam int unsigned LOC_W = $clog2(GROUP);

    // ---------------------------------------------------------------- flow control
    logic out_vld_q;
    logic s1_vld_q;
    logic out_adv;
    logic s1_adv;

    assign out_adv    = !out_vld_q || bus.out_rdy;
    assign s1_adv     = !s1_vld_q || out_adv;
    assign bus.in_rdy = s1_adv;

    // ---------------------------------------------------------------- stage 1 combinational
    logic [NGRP-1:0]            grp_any;
    logic [NGRP-1:0][LOC_W-1:0] grp_loc;

    // Ascending scan, later hits overwrite earlier ones: the highest set bit wins.
    always_comb begin
        grp_any = '0;
        grp_loc = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_any[g] = |bus.in_data[g*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                if (bus.in_data[g*GROUP + i]) begin
                    grp_loc[g] = LOC_W'(i);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 1 registers
    logic [NGRP-1:0]            s1_any_q;
    logic [NGRP-1:0][LOC_W-1:0] s1_loc_q;
`ifdef LOD_NORM_EN
    logic [WIDTH-1:0]           s1_data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_any_q  <= '0;
            s1_loc_q  <= '0;
`ifdef LOD_NORM_EN
            s1_data_q <= '0;
`endif
        end else if (s1_adv) begin
            s1_vld_q <= bus.in_vld;
            // Payload only moves on a real transfer; bubbles leave it untouched.
            if (bus.in_vld) begin
                s1_any_q  <= grp_any;
                s1_loc_q  <= grp_loc;
`ifdef LOD_NORM_EN
                s1_data_q <= bus.in_data;
`endif
            end
        end
    end

    // ---------------------------------------------------------------- stage 2 combinational
    logic [IDX_W-1:0] sel_idx;
    logic             sel_zero;

    always_comb begin
        sel_idx  = '0;
        sel_zero = 1'b1;
        for (int g = 0; g < NGRP; g++) begin
            if (s1_any_q[g]) begin
                sel_idx  = IDX_W'(g * GROUP) + IDX_W'(s1_loc_q[g]);
                sel_zero = 1'b0;
            end
        end
    end

`ifdef LOD_NORM_EN
    logic [WIDTH-1:0] sel_data;

    // WIDTH-1 always fits in IDX_W bits, so the subtraction never wraps for a valid index.
    always_comb begin
        sel_data = '0;
        if (!sel_zero) begin
            sel_data = s1_data_q << (IDX_W'(WIDTH - 1) - sel_idx);
        end
    end
`endif

    // ---------------------------------------------------------------- stage 2 registers
    logic [IDX_W-1:0] out_idx_q;
    logic             out_zero_q;
`ifdef LOD_NORM_EN
    logic [WIDTH-1:0] out_data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_idx_q  <= '0;
            out_zero_q <= 1'b0;
`ifdef LOD_NORM_EN
            out_data_q <= '0;
`endif
        end else if (out_adv) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_idx_q  <= sel_idx;
                out_zero_q <= sel_zero;
`ifdef LOD_NORM_EN
                out_data_q <= sel_data;
`endif
            end
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.out_zero = out_zero_q;
`ifdef LOD_NORM_EN
    assign bus.out_data = out_data_q;
`endif

endmodule

// File: tb/tb_lod_pipe.sv
// Directed bench for lod_pipe (WIDTH=32, GROUP=8). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.

module tb_lod_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned GROUP = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    lod_pipe_if #(.WIDTH(WIDTH)) bus ();

    lod_pipe #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-word vectors: input, index, zero flag, normalised word.
    logic [31:0] vec_in   [5] = '{32'h8000_0000, 32'h0000_0001, 32'h0001_FFFF, 32'h0000_0000,
                                  32'h0000_0300};
    logic [4:0]  vec_idx  [5] = '{5'd31, 5'd0, 5'd16, 5'd0, 5'd9};
    logic        vec_zero [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vec_norm [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_8000, 32'h0000_0000,
                                  32'hC000_0000};

    // Stall stream: single bits 20..25.
    logic [31:0] st_in  [6] = '{32'h0010_0000, 32'h0020_0000, 32'h0040_0000, 32'h0080_0000,
                                32'h0100_0000, 32'h0200_0000};
    logic [4:0]  st_idx [6] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld);
        end
        n_tests++;
        if (bus.out_idx !== 5'd0) begin
            n_fail++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx);
        end
        n_tests++;
        if (bus.out_zero !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_zero: got %b want 0", bus.out_zero);
        end
`ifdef LOD_NORM_EN
        n_tests++;
        if (bus.out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy);
        end
        n_tests++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_vld: got %b want 0", bus.out_vld);
        end
    endtask

    task automatic test_single();
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_vld  = 1'b1;
            bus.in_data = vec_in[i];
            #1;
            n_tests++;
            if (bus.in_rdy !== 1'b1) begin
                n_fail++; $display("FAIL single_in_rdy[%0d]: got %b want 1", i, bus.in_rdy);
            end
            @(negedge clk);
            bus.in_vld  = 1'b0;
            bus.in_data = '0;
            #1;
            n_tests++;
            if (bus.out_vld !== 1'b0) begin
                n_fail++; $display("FAIL single_early_vld[%0d]: got %b want 0", i, bus.out_vld);
            end
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.out_vld !== 1'b1 || bus.out_idx !== vec_idx[i]
                || bus.out_zero !== vec_zero[i]) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got vld=%b idx=%0d zero=%b want vld=1 idx=%0d zero=%b",
                         i, bus.out_vld, bus.out_idx, bus.out_zero, vec_idx[i], vec_zero[i]);
            end
`ifdef LOD_NORM_EN
            n_tests++;
            if (bus.out_data !== vec_norm[i]) begin
                n_fail++;
                $display("FAIL single_norm[%0d]: got %h want %h", i, bus.out_data, vec_norm[i]);
            end
`endif
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.out_vld !== 1'b0) begin
                n_fail++; $display("FAIL single_drain[%0d]: got %b want 0", i, bus.out_vld);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 8) begin
                bus.in_vld  = 1'b1;
                bus.in_data = 32'h1 << c;
            end else begin
                bus.in_vld  = 1'b0;
                bus.in_data = '0;
            end
            #1;
            n_tests++;
            if (c >= 2) begin
                if (bus.out_vld !== 1'b1 || bus.out_idx !== 5'(c - 2)) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got vld=%b idx=%0d want vld=1 idx=%0d",
                             c, bus.out_vld, bus.out_idx, c - 2);
                end
            end else if (bus.out_vld !== 1'b0) begin
                n_fail++; $display("FAIL b2b_fill[%0d]: got vld=%b want 0", c, bus.out_vld);
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got vld=%b want 0", bus.out_vld);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int rcv  = 0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            @(negedge clk);
            bus.out_rdy = (c >= 5);
            bus.in_vld  = (sent < 6);
            bus.in_data = (sent < 6) ? st_in[sent] : '0;
            #1;
            if (c < 5) begin
                n_tests++;
                if (bus.in_rdy !== (c < 2)) begin
                    n_fail++;
                    $display("FAIL stall_in_rdy[%0d]: got %b want %b", c, bus.in_rdy, c < 2);
                end
                if (c >= 2) begin
                    n_tests++;
                    if (bus.out_vld !== 1'b1 || bus.out_idx !== st_idx[0]) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: got vld=%b idx=%0d want vld=1 idx=%0d",
                                 c, bus.out_vld, bus.out_idx, st_idx[0]);
                    end
                end
            end
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
                n_tests++;
                if (bus.out_idx !== st_idx[rcv]) begin
                    n_fail++;
                    $display("FAIL stall_order[%0d]: got idx=%0d want %0d",
                             rcv, bus.out_idx, st_idx[rcv]);
                end
                rcv++;
            end
            if (bus.in_vld === 1'b1 && bus.in_rdy === 1'b1) sent++;
        end
        n_tests++;
        if (rcv != 6) begin
            n_fail++; $display("FAIL stall_count: got %0d results want 6", rcv);
        end
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL stall_extra: got vld=%b want 0", bus.out_vld);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_rdy = 1'b0;
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_data = 32'h0000_8000;
        @(negedge clk);
        bus.in_data = 32'h0000_0040;
        @(negedge clk);
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b1 || bus.out_idx !== 5'd15 || bus.in_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_full: got vld=%b idx=%0d in_rdy=%b want vld=1 idx=15 in_rdy=0",
                     bus.out_vld, bus.out_idx, bus.in_rdy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b0 || bus.out_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got vld=%b idx=%0d want vld=0 idx=0",
                     bus.out_vld, bus.out_idx);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_stale[%0d]: got vld=%b in_rdy=%b want vld=0 in_rdy=1",
                         c, bus.out_vld, bus.in_rdy);
            end
        end
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_data = 32'h0000_0300;
        @(negedge clk);
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.out_vld !== 1'b1 || bus.out_idx !== 5'd9 || bus.out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_resume: got vld=%b idx=%0d zero=%b want vld=1 idx=9 zero=0",
                     bus.out_vld, bus.out_idx, bus.out_zero);
        end
`ifdef LOD_NORM_EN
        n_tests++;
        if (bus.out_data !== 32'hC000_0000) begin
            n_fail++; $display("FAIL rstmid_norm: got %h want c0000000", bus.out_data);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
